hazard_ctrl: RTL and testbench

Pipeline hazard controller consuming the 6-bit hazard code produced each cycle by the ID-stage hazard detector. Converts that code into PC/IF-ID hold, IF-ID flush and ID/EX bubble strobes, and registers the EX-stage operand forwarding selects into the ID/EX boundary. Owns the one-cycle load-use stall sequence, including the MEM/WB forward the detector cannot see after the bubble, and keeps saturating stall/flush counters for debug.

---
 rtl/hazard_ctrl.sv | 150 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: turns the ID-stage hazard code into PC/IF-ID hold, IF-ID flush
// and ID/EX bubble strobes, registers the EX operand forwarding selects, runs
// the one-cycle load-use stall (with the follow-up MEM/WB forward the detector
// cannot see), and keeps saturating stall/flush debug counters.
module hazard_ctrl #(
    parameter int STALL_CW = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [5:0]          outtype,
    input  logic                valid_d,
    input  logic [4:0]          rs_d,
    input  logic [4:0]          rt_d,
    input  logic [4:0]          ld_dst_e,
    input  logic                branch_taken_e,
    output logic                pc_en,
    output logic                ifid_en,
    output logic                ifid_flush,
    output logic                idex_bubble,
    output logic [1:0]          fwd_a_e,
    output logic [1:0]          fwd_b_e,
    output logic [STALL_CW-1:0] stall_cnt,
    output logic [STALL_CW-1:0] flush_cnt
);

    localparam logic [5:0]          LOAD_USE = 6'b111111;
    localparam logic [STALL_CW-1:0] CNT_ONE  = {{(STALL_CW-1){1'b0}}, 1'b1};

    // Forwarding select encodings shared by both operand muxes.
    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_WB  = 2'b10;
    localparam logic [1:0] SEL_IMM = 2'b11;

    typedef enum logic {
        RUN   = 1'b0,
        LDFWD = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          fwd_a_q, fwd_a_d;
    logic [1:0]          fwd_b_q, fwd_b_d;
    logic [STALL_CW-1:0] stall_cnt_q, stall_cnt_d;
    logic [STALL_CW-1:0] flush_cnt_q, flush_cnt_d;
    logic [4:0]          ld_dst_q, ld_dst_d;

    logic       is_load_use;
    logic       stall_now;
    logic [1:0] code_a;
    logic [1:0] code_b;
    logic [1:0] dec_a;
    logic [1:0] dec_b;
    logic       rs_nz;
    logic       rt_nz;
    logic       rs_hit;
    logic       rt_hit;

    function automatic logic [STALL_CW-1:0] sat_inc(input logic [STALL_CW-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    // The load-use code carries no operand fields, so it decodes as "no forward".
    assign is_load_use = (outtype == LOAD_USE);
    assign code_a      = is_load_use ? 2'b00 : outtype[3:2];
    assign code_b      = is_load_use ? 2'b00 : outtype[1:0];

    assign rs_nz  = (rs_d != 5'd0);
    assign rt_nz  = (rt_d != 5'd0);
    // Match against the load held back by the previous stall; register 0 never forwards.
    assign rs_hit = (rs_d == ld_dst_q) && rs_nz;
    assign rt_hit = (rt_d == ld_dst_q) && rt_nz;

    // A taken branch squashes the stalled instruction, so it also cancels the stall.
    assign stall_now   = (state_q == RUN) && valid_d && is_load_use && !branch_taken_e;
    assign pc_en       = !stall_now;
    assign ifid_en     = !stall_now;
    assign ifid_flush  = branch_taken_e;
    assign idex_bubble = stall_now || branch_taken_e;

    assign fwd_a_e   = fwd_a_q;
    assign fwd_b_e   = fwd_b_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

    // Decode the detector's operand codes with the register-0 guard.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        dec_a = SEL_RF;
        dec_b = SEL_RF;
        if (code_a == 2'b01 && rs_nz) begin
            dec_a = SEL_MEM;
        end
        if (code_b == 2'b11) begin
            dec_b = SEL_IMM;
        end else if (code_b == 2'b01 && rt_nz) begin
            dec_b = SEL_MEM;
        end
    end

    // Next state, next forwarding selects and counter updates, in priority order.
    always_comb begin
        state_d     = RUN;
        fwd_a_d     = SEL_RF;
        fwd_b_d     = SEL_RF;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        ld_dst_d    = ld_dst_q;
        if (branch_taken_e) begin
            flush_cnt_d = sat_inc(flush_cnt_q);
        end else if (stall_now) begin
            state_d     = LDFWD;
            ld_dst_d    = ld_dst_e;
            stall_cnt_d = sat_inc(stall_cnt_q);
        end else if (valid_d) begin
            if (state_q == LDFWD) begin
                // The load has moved to WB; the detector only sees EX/MEM, so add the WB forward here.
                fwd_a_d = rs_hit ? SEL_WB : dec_a;
                if (code_b == 2'b11) begin
                    fwd_b_d = SEL_IMM;
                end else begin
                    fwd_b_d = rt_hit ? SEL_WB : dec_b;
                end
            end else begin
                fwd_a_d = dec_a;
                fwd_b_d = dec_b;
            end
        end
    end

    // State, select and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q     <= RUN;
            fwd_a_q     <= SEL_RF;
            fwd_b_q     <= SEL_RF;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            ld_dst_q    <= 5'd0;
        end else begin
            state_q     <= state_d;
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            ld_dst_q    <= ld_dst_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: a vector table walks the main paths and corner
// sequences on a 16-bit-counter instance; a 2-bit-counter instance shares the
// inputs and is used for the counter saturation sequence.
module tb_hazard_ctrl;

    logic        clk;
    logic        reset;
    logic [5:0]  outtype;
    logic        valid_d;
    logic [4:0]  rs_d;
    logic [4:0]  rt_d;
    logic [4:0]  ld_dst_e;
    logic        branch_taken_e;

    logic        pc_en, ifid_en, ifid_flush, idex_bubble;
    logic [1:0]  fwd_a_e, fwd_b_e;
    logic [15:0] stall_cnt, flush_cnt;

    logic        s_pc_en, s_ifid_en, s_ifid_flush, s_idex_bubble;
    logic [1:0]  s_fwd_a_e, s_fwd_b_e;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    hazard_ctrl #(.STALL_CW(16)) u_dut (
        .clk(clk), .reset(reset), .outtype(outtype), .valid_d(valid_d),
        .rs_d(rs_d), .rt_d(rt_d), .ld_dst_e(ld_dst_e), .branch_taken_e(branch_taken_e),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
        .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_ctrl #(.STALL_CW(2)) u_sat (
        .clk(clk), .reset(reset), .outtype(outtype), .valid_d(valid_d),
        .rs_d(rs_d), .rt_d(rt_d), .ld_dst_e(ld_dst_e), .branch_taken_e(branch_taken_e),
        .pc_en(s_pc_en), .ifid_en(s_ifid_en), .ifid_flush(s_ifid_flush), .idex_bubble(s_idex_bubble),
        .fwd_a_e(s_fwd_a_e), .fwd_b_e(s_fwd_b_e), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string       nm;
        logic        rst;
        logic [5:0]  ot;
        logic        v;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  ld;
        logic        br;
        logic        pc;
        logic        ifid;
        logic        fl;
        logic        bub;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [15:0] sc;
        logic [15:0] fc;
    } vec_t;

    typedef struct {
        string       nm;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [15:0] sc;
        logic [15:0] fc;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   sat_q[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input string nm, input logic rst, input logic [5:0] ot,
                                input logic v, input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] ld, input logic br,
                                input logic pc, input logic ifid, input logic fl, input logic bub,
                                input logic [1:0] fa, input logic [1:0] fb,
                                input int sc, input int fc);
        vec_t r;
        r.nm = nm; r.rst = rst; r.ot = ot; r.v = v; r.rs = rs; r.rt = rt; r.ld = ld; r.br = br;
        r.pc = pc; r.ifid = ifid; r.fl = fl; r.bub = bub; r.fa = fa; r.fb = fb;
        r.sc = 16'(sc); r.fc = 16'(fc);
        return r;
    endfunction

    task automatic drive(input logic rst, input logic [5:0] ot, input logic v,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] ld,
                         input logic br);
        reset          = rst;
        outtype        = ot;
        valid_d        = v;
        rs_d           = rs;
        rt_d           = rt;
        ld_dst_e       = ld;
        branch_taken_e = br;
    endtask

    initial begin
        exp_t e;
        drive(1'b1, 6'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);

        //          name          rst ot          v  rs  rt  ld  br  pc ifid fl bub fa     fb     sc fc
        vecs.push_back(mk("rst0",     1, 6'b000000, 0, 0,  0,  0,  0,  1, 1,  0, 0,  2'b00, 2'b00, 0, 0));
        vecs.push_back(mk("rst1",     1, 6'b000000, 0, 0,  0,  0,  0,  1, 1,  0, 0,  2'b00, 2'b00, 0, 0));
        vecs.push_back(mk("alu_alu",  0, 6'b000101, 1, 3,  4,  0,  0,  1, 1,  0, 0,  2'b01, 2'b01, 0, 0));
        vecs.push_back(mk("ld_stall", 0, 6'b111111, 1, 5,  6,  5,  0,  0, 0,  0, 1,  2'b00, 2'b00, 1, 0));
        vecs.push_back(mk("ld_wbfwd", 0, 6'b000000, 1, 5,  6,  0,  0,  1, 1,  0, 0,  2'b10, 2'b00, 1, 0));
        vecs.push_back(mk("st_alu",   0, 6'b000111, 1, 2,  7,  0,  0,  1, 1,  0, 0,  2'b01, 2'b11, 1, 0));
        vecs.push_back(mk("st_r0",    0, 6'b000111, 1, 0,  7,  0,  0,  1, 1,  0, 0,  2'b00, 2'b11, 1, 0));
        vecs.push_back(mk("b_rt0",    0, 6'b000001, 1, 3,  0,  0,  0,  1, 1,  0, 0,  2'b00, 2'b00, 1, 0));
        vecs.push_back(mk("code10",   0, 6'b001010, 1, 3,  4,  0,  0,  1, 1,  0, 0,  2'b00, 2'b00, 1, 0));
        vecs.push_back(mk("a_code11", 0, 6'b001100, 1, 3,  4,  0,  0,  1, 1,  0, 0,  2'b00, 2'b00, 1, 0));
        vecs.push_back(mk("nv_ld",    0, 6'b111111, 0, 5,  6,  5,  0,  1, 1,  0, 0,  2'b00, 2'b00, 1, 0));
        vecs.push_back(mk("nv_alu",   0, 6'b000101, 0, 3,  4,  0,  0,  1, 1,  0, 0,  2'b00, 2'b00, 1, 0));
        vecs.push_back(mk("br_stall", 0, 6'b111111, 1, 5,  6,  5,  1,  1, 1,  1, 1,  2'b00, 2'b00, 1, 1));
        vecs.push_back(mk("br_after", 0, 6'b000101, 1, 5,  4,  0,  0,  1, 1,  0, 0,  2'b01, 2'b01, 1, 1));
        vecs.push_back(mk("ld_rt",    0, 6'b111111, 1, 1,  9,  9,  0,  0, 0,  0, 1,  2'b00, 2'b00, 2, 1));
        vecs.push_back(mk("ldfwd_ign",0, 6'b111111, 1, 1,  9,  0,  0,  1, 1,  0, 0,  2'b00, 2'b10, 2, 1));
        vecs.push_back(mk("ld_both",  0, 6'b111111, 1, 9,  9,  9,  0,  0, 0,  0, 1,  2'b00, 2'b00, 3, 1));
        vecs.push_back(mk("ldfwd_imm",0, 6'b000111, 1, 9,  9,  0,  0,  1, 1,  0, 0,  2'b10, 2'b11, 3, 1));
        vecs.push_back(mk("ld_r0",    0, 6'b111111, 1, 0,  0,  0,  0,  0, 0,  0, 1,  2'b00, 2'b00, 4, 1));
        vecs.push_back(mk("ldfwd_r0", 0, 6'b000000, 1, 0,  0,  0,  0,  1, 1,  0, 0,  2'b00, 2'b00, 4, 1));
        vecs.push_back(mk("ld_4",     0, 6'b111111, 1, 4,  4,  4,  0,  0, 0,  0, 1,  2'b00, 2'b00, 5, 1));
        vecs.push_back(mk("ldfwd_br", 0, 6'b000000, 1, 4,  4,  0,  1,  1, 1,  1, 1,  2'b00, 2'b00, 5, 2));
        vecs.push_back(mk("br_run",   0, 6'b000000, 1, 4,  4,  0,  0,  1, 1,  0, 0,  2'b00, 2'b00, 5, 2));
        vecs.push_back(mk("ld_4b",    0, 6'b111111, 1, 4,  4,  4,  0,  0, 0,  0, 1,  2'b00, 2'b00, 6, 2));
        vecs.push_back(mk("rst_ldfwd",1, 6'b000000, 0, 4,  4,  0,  0,  1, 1,  0, 0,  2'b00, 2'b00, 0, 0));
        vecs.push_back(mk("post_rst", 0, 6'b000000, 1, 4,  4,  0,  0,  1, 1,  0, 0,  2'b00, 2'b00, 0, 0));
        vecs.push_back(mk("ld_7",     0, 6'b111111, 1, 7,  7,  7,  0,  0, 0,  0, 1,  2'b00, 2'b00, 1, 0));
        vecs.push_back(mk("ldfwd_nv", 0, 6'b000000, 0, 7,  7,  0,  0,  1, 1,  0, 0,  2'b00, 2'b00, 1, 0));
        vecs.push_back(mk("nv_run",   0, 6'b000101, 1, 7,  7,  0,  0,  1, 1,  0, 0,  2'b01, 2'b01, 1, 0));

        // Table: drive each vector mid-cycle, check strobes, score the registered result after the edge.
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].ot, vecs[i].v, vecs[i].rs, vecs[i].rt, vecs[i].ld, vecs[i].br);
            #1;
            check($sformatf("%s.pc_en", vecs[i].nm),       32'(pc_en),       32'(vecs[i].pc));
            check($sformatf("%s.ifid_en", vecs[i].nm),     32'(ifid_en),     32'(vecs[i].ifid));
            check($sformatf("%s.ifid_flush", vecs[i].nm),  32'(ifid_flush),  32'(vecs[i].fl));
            check($sformatf("%s.idex_bubble", vecs[i].nm), 32'(idex_bubble), 32'(vecs[i].bub));
            exp_q.push_back('{nm: vecs[i].nm, fa: vecs[i].fa, fb: vecs[i].fb, sc: vecs[i].sc, fc: vecs[i].fc});
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            check($sformatf("%s.fwd_a_e", e.nm),   32'(fwd_a_e),   32'(e.fa));
            check($sformatf("%s.fwd_b_e", e.nm),   32'(fwd_b_e),   32'(e.fb));
            check($sformatf("%s.stall_cnt", e.nm), 32'(stall_cnt), 32'(e.sc));
            check($sformatf("%s.flush_cnt", e.nm), 32'(flush_cnt), 32'(e.fc));
        end

        // Saturation on the 2-bit instance: a held load-use code stalls every other cycle.
        @(negedge clk);
        drive(1'b1, 6'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        @(posedge clk);
        #1;
        check("sat.reset_cnt", 32'(s_stall_cnt), 32'd0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            drive(1'b0, 6'b111111, 1'b1, 5'd5, 5'd6, 5'd5, 1'b0);
            sat_q.push_back(((k / 2) + 1 > 3) ? 3 : (k / 2) + 1);
            @(posedge clk);
            #1;
            check($sformatf("sat.stall_cnt[%0d]", k), 32'(s_stall_cnt), 32'(sat_q.pop_front()));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
